// File: rtl/rvm_adder_arbiter_pkg.sv
// ============================================================================
// Module   : rvm_adder_arbiter_pkg
// Purpose  : Shared adder op encodings and arbiter state encodings.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rvm_adder_arbiter_pkg;

  localparam logic [2:0] RVM_ARITH_NOP = 3'b000;
  localparam logic [2:0] RVM_ARITH_ADD = 3'b001;
  localparam logic [2:0] RVM_ARITH_SUB = 3'b010;

  typedef logic [1:0] addarb_state_t;

  localparam addarb_state_t RVM_ADDARB_IDLE = 2'd0;
  localparam addarb_state_t RVM_ADDARB_EXEC = 2'd1;
  localparam addarb_state_t RVM_ADDARB_RESP = 2'd2;

  function automatic logic is_defined_op(input logic [2:0] op);
    return (op == RVM_ARITH_NOP) || (op == RVM_ARITH_ADD) || (op == RVM_ARITH_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvm_adder.sv
// ============================================================================
// Module   : rvm_adder
// Purpose  : Combinational 32-bit add/sub with carry/borrow, overflow, bad-op.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rvm_adder
  import rvm_adder_arbiter_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  output logic [32:0] result,
  output logic        ovf,
  output logic        err
);

  always_comb begin
    result = 33'd0;
    ovf    = 1'b0;
    err    = !is_defined_op(op);
    case (op)
      RVM_ARITH_ADD: begin
        result = {1'b0, lhs} + {1'b0, rhs};
        ovf    = (lhs[31] == rhs[31]) && (result[31] != lhs[31]);
      end
      RVM_ARITH_SUB: begin
        // bit 32 of the 33-bit difference is the unsigned borrow
        result = {1'b0, lhs} - {1'b0, rhs};
        ovf    = (lhs[31] != rhs[31]) && (result[31] != lhs[31]);
      end
      default: begin
        result = 33'd0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rvm_rr_pick.sv
// ============================================================================
// Module   : rvm_rr_pick
// Purpose  : Combinational round-robin picker, searching upward from last+1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rvm_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      idx
);

  logic w_found;

  always_comb begin
    grant   = '0;
    idx     = 3'd0;
    w_found = 1'b0;
    // offset k walks priority order; i is kept constant for static indexing
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req[i] && (i == ((int'(last) + k) % NREQ))) begin
          w_found  = 1'b1;
          grant[i] = 1'b1;
          idx      = 3'(i);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rvm_adder_arbiter.sv
// ============================================================================
// Module   : rvm_adder_arbiter
// Purpose  : Round-robin front-end sharing one rvm_adder, one op in flight.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rvm_adder_arbiter
  import rvm_adder_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [3*NREQ-1:0]  req_op,
  input  logic [32*NREQ-1:0] req_lhs,
  input  logic [32*NREQ-1:0] req_rhs,
  output logic [NREQ-1:0]  req_ready,
  output logic             rsp_valid,
  output logic [2:0]       rsp_id,
  output logic [32:0]      rsp_result,
  output logic             rsp_ovf,
  output logic             rsp_err,
  input  logic             rsp_ready
);

  addarb_state_t r_state;
  addarb_state_t w_next_state;

  logic [2:0]      r_last;
  logic [2:0]      r_op;
  logic [2:0]      r_id;
  logic [31:0]     r_lhs;
  logic [31:0]     r_rhs;
  logic [2:0]      r_rsp_id;
  logic [32:0]     r_rsp_result;
  logic            r_rsp_ovf;
  logic            r_rsp_err;

  logic            w_grant_opp;
  logic [NREQ-1:0] w_pick_grant;
  logic [2:0]      w_pick_idx;
  logic [2:0]      w_sel_op;
  logic [31:0]     w_sel_lhs;
  logic [31:0]     w_sel_rhs;
  logic [2:0]      w_add_op;
  logic [31:0]     w_add_lhs;
  logic [31:0]     w_add_rhs;
  logic [32:0]     w_add_result;
  logic            w_add_ovf;
  logic            w_add_err;

  rvm_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .last  (r_last),
    .grant (w_pick_grant),
    .idx   (w_pick_idx)
  );

  rvm_adder u_adder (
    .op     (w_add_op),
    .lhs    (w_add_lhs),
    .rhs    (w_add_rhs),
    .result (w_add_result),
    .ovf    (w_add_ovf),
    .err    (w_add_err)
  );

  // A new op may start from IDLE, or from RESP in the same cycle it is consumed
  assign w_grant_opp = !reset && (|req_valid) &&
                       ((r_state == RVM_ADDARB_IDLE) ||
                        ((r_state == RVM_ADDARB_RESP) && rsp_ready));

  always_comb begin
    w_sel_op  = RVM_ARITH_NOP;
    w_sel_lhs = 32'd0;
    w_sel_rhs = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_grant[i]) begin
        w_sel_op  = req_op[3*i +: 3];
        w_sel_lhs = req_lhs[32*i +: 32];
        w_sel_rhs = req_rhs[32*i +: 32];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RVM_ADDARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RVM_ADDARB_IDLE: if (w_grant_opp) w_next_state = RVM_ADDARB_EXEC;
      RVM_ADDARB_EXEC: w_next_state = RVM_ADDARB_RESP;
      RVM_ADDARB_RESP: begin
        if (rsp_ready) begin
          w_next_state = w_grant_opp ? RVM_ADDARB_EXEC : RVM_ADDARB_IDLE;
        end
      end
      default:         w_next_state = RVM_ADDARB_IDLE;
    endcase
  end

  // Outputs; adder sees NOP with zero operands outside EXEC
  always_comb begin
    req_ready = w_grant_opp ? w_pick_grant : '0;
    rsp_valid = (r_state == RVM_ADDARB_RESP);
    w_add_op  = RVM_ARITH_NOP;
    w_add_lhs = 32'd0;
    w_add_rhs = 32'd0;
    if (r_state == RVM_ADDARB_EXEC) begin
      w_add_op  = r_op;
      w_add_lhs = r_lhs;
      w_add_rhs = r_rhs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last       <= 3'(NREQ - 1);
      r_op         <= RVM_ARITH_NOP;
      r_id         <= 3'd0;
      r_lhs        <= 32'd0;
      r_rhs        <= 32'd0;
      r_rsp_id     <= 3'd0;
      r_rsp_result <= 33'd0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_grant_opp) begin
        r_last <= w_pick_idx;
        r_id   <= w_pick_idx;
        r_op   <= w_sel_op;
        r_lhs  <= w_sel_lhs;
        r_rhs  <= w_sel_rhs;
      end
      if (r_state == RVM_ADDARB_EXEC) begin
        r_rsp_id     <= r_id;
        r_rsp_result <= w_add_result;
        r_rsp_ovf    <= w_add_ovf;
        r_rsp_err    <= w_add_err;
      end
    end
  end

  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_ovf    = r_rsp_ovf;
  assign rsp_err    = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_rvm_adder_arbiter.sv
// ============================================================================
// Module   : tb_rvm_adder_arbiter
// Purpose  : Directed bench with a transaction-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rvm_adder_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_lhs;
  logic [32*NREQ-1:0] req_rhs;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [32:0]       rsp_result;
  logic              rsp_ovf;
  logic              rsp_err;
  logic              rsp_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  rvm_adder_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [32:0] res, output logic ovf, output logic err);
    longint ua, ub, sa, sb, s;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 33'd0; ovf = 1'b0; err = 1'b0;
    if (op == 3'b001) begin
      res = 33'(ua + ub);
      s   = sa + sb;
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (op == 3'b010) begin
      res = 33'(ua - ub);
      s   = sa - sb;
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (op != 3'b000) begin
      err = 1'b1;
    end
  endtask

  logic        m_exec = 1'b0, m_resp = 1'b0;
  int          m_last = NREQ - 1;
  logic [2:0]  m_op;
  logic [31:0] m_l, m_r;
  int          m_id;
  int          m_id_out = 0;
  logic [32:0] m_res = '0;
  logic        m_ovf = 1'b0, m_err = 1'b0;
  int          grant_log[$];
  int          grant_cyc[$];

  always @(negedge clk) begin
    logic            opp;
    int              w;
    logic [NREQ-1:0] exp_ready;
    opp = !reset && (|req_valid) && !m_exec && (!m_resp || rsp_ready);
    w   = opp ? pick(req_valid, m_last) : -1;
    exp_ready = '0;
    if (opp) exp_ready[w] = 1'b1;
    cmp("req_ready", 64'(req_ready), 64'(exp_ready));
    cmp("rsp_valid", 64'(rsp_valid), 64'(m_resp));
    if (m_resp) begin
      cmp("rsp_id", 64'(rsp_id), 64'(m_id_out));
      cmp("rsp_result", 64'(rsp_result), 64'(m_res));
      cmp("rsp_ovf", 64'(rsp_ovf), 64'(m_ovf));
      cmp("rsp_err", 64'(rsp_err), 64'(m_err));
    end
    if (opp) begin
      grant_log.push_back(w);
      grant_cyc.push_back(cyc);
    end
    if (reset) begin
      m_exec = 1'b0; m_resp = 1'b0; m_last = NREQ - 1;
      m_res = '0; m_ovf = 1'b0; m_err = 1'b0; m_id_out = 0;
    end else begin
      if (m_exec) begin
        model_op(m_op, m_l, m_r, m_res, m_ovf, m_err);
        m_id_out = m_id;
        m_exec = 1'b0;
        m_resp = 1'b1;
      end else if (m_resp && rsp_ready) begin
        m_resp = 1'b0;
      end
      if (opp) begin
        m_op = req_op[3*w +: 3];
        m_l  = req_lhs[32*w +: 32];
        m_r  = req_rhs[32*w +: 32];
        m_id = w;
        m_last = w;
        m_exec = 1'b1;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] l, input logic [31:0] r);
    req_valid[i]       = 1'b1;
    req_op[3*i +: 3]   = op;
    req_lhs[32*i +: 32] = l;
    req_rhs[32*i +: 32] = r;
  endtask

  task automatic wait_grant(input int i, output int n);
    n = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        n = k;
        break;
      end
    end
    if (n < 0) cmp("grant_timeout", 64'(i), 64'hFF);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(output int n, output logic [32:0] res, output logic ovf,
                           output logic err, output logic [2:0] id);
    n = -1; res = '0; ovf = 1'b0; err = 1'b0; id = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = k; res = rsp_result; ovf = rsp_ovf; err = rsp_err; id = rsp_id;
        break;
      end
    end
    if (n < 0) cmp("resp_timeout", 64'(n), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [32:0] res, held;
    logic        ovf, err;
    logic [2:0]  id;

    reset = 1'b1; req_valid = '0; req_op = '0; req_lhs = '0; req_rhs = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    cmp("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    cmp("reset_rsp_result", 64'(rsp_result), 64'd0);
    cmp("reset_rsp_id", 64'(rsp_id), 64'd0);
    cmp("reset_req_ready", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    tick();

    // Single ADD with carry-out
    set_req(0, 3'b001, 32'hFFFF_FFFF, 32'h1);
    wait_grant(0, n);
    cmp("add_grant_latency", 64'(n), 64'd0);
    wait_resp(n, res, ovf, err, id);
    cmp("add_rsp_latency", 64'(n), 64'd1);
    cmp("add_result", 64'(res), 64'h1_0000_0000);
    cmp("add_flags", 64'({id, ovf, err}), 64'({3'd0, 1'b0, 1'b0}));

    // SUB signed overflow
    set_req(2, 3'b010, 32'h8000_0000, 32'h1);
    wait_grant(2, n);
    wait_resp(n, res, ovf, err, id);
    cmp("sub_result", 64'(res), 64'h0_7FFF_FFFF);
    cmp("sub_ovf", 64'(ovf), 64'd1);
    cmp("sub_id", 64'(id), 64'd2);

    // Undefined op, then NOP
    set_req(1, 3'b011, 32'd5, 32'd7);
    wait_grant(1, n);
    wait_resp(n, res, ovf, err, id);
    cmp("undef_result", 64'(res), 64'd0);
    cmp("undef_err", 64'(err), 64'd1);
    set_req(1, 3'b110, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_grant(1, n);
    wait_resp(n, res, ovf, err, id);
    cmp("undef_hi_flags", 64'({res, ovf, err}), 64'({33'd0, 1'b0, 1'b1}));
    set_req(3, 3'b000, 32'd9, 32'd4);
    wait_grant(3, n);
    wait_resp(n, res, ovf, err, id);
    cmp("nop_flags", 64'({res, ovf, err}), 64'({33'd0, 1'b0, 1'b0}));
    cmp("nop_id", 64'(id), 64'd3);

    // Fairness: all requesters held high, consumer always ready
    repeat (2) tick();
    grant_log.delete();
    grant_cyc.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 3'b001, 32'(i) * 32'h100, (i == 3) ? 32'h7FFF_FFFF : 32'h10);
    req_lhs[32*3 +: 32] = 32'h0000_0001;
    repeat (10) tick();
    req_valid = '0;
    repeat (4) tick();
    cmp("fair_count", 64'(grant_log.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < grant_log.size()) begin
        cmp("fair_order", 64'(grant_log[k]), 64'(k % NREQ));
        if (k > 0) cmp("fair_spacing", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd2);
      end
    end

    // Backpressure: response held while requester 1 waits
    rsp_ready = 1'b0;
    set_req(0, 3'b001, 32'd10, 32'd20);
    wait_grant(0, n);
    wait_resp(n, held, ovf, err, id);
    cmp("bp_first_result", 64'(held), 64'd30);
    set_req(1, 3'b010, 32'd3, 32'd5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmp("bp_no_grant", 64'(req_ready), 64'd0);
      cmp("bp_hold_valid", 64'(rsp_valid), 64'd1);
      cmp("bp_hold_result", 64'(rsp_result), 64'(held));
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    cmp("bp_release_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid[1] = 1'b0;
    wait_resp(n, res, ovf, err, id);
    cmp("bp_sub_borrow", 64'(res), 64'h1_FFFF_FFFE);
    cmp("bp_sub_id", 64'(id), 64'd1);
    repeat (2) tick();

    // Reset while the op is in EXEC
    set_req(2, 3'b001, 32'd1, 32'd2);
    wait_grant(2, n);
    reset = 1'b1;
    @(negedge clk);
    cmp("rst_req_ready", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cmp("rst_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    set_req(3, 3'b001, 32'd4, 32'd4);
    set_req(0, 3'b010, 32'd8, 32'd3);
    @(negedge clk);
    cmp("rst_ptr_first", 64'(req_ready), 64'b0001);
    tick();
    req_valid[0] = 1'b0;
    wait_grant(3, n);
    cmp("rst_ptr_second", 64'(n), 64'd1);
    wait_resp(n, res, ovf, err, id);
    cmp("rst_last_result", 64'(res), 64'd8);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
